// File: rtl/field_reader_if.sv
// Request/response handshake bundle for field_reader.
interface field_reader_if #(
  parameter int SELW = 1,
  parameter int OFFW = 8,
  parameter int ACCW = 16
);
  logic            req_valid;
  logic            req_ready;
  logic            req_sweep;
  logic [SELW-1:0] req_sel;
  logic [OFFW-1:0] req_off;
  logic [OFFW-1:0] req_end;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ACCW-1:0] rsp_data;
  logic            rsp_oob;

  modport master (
    output req_valid, req_sweep, req_sel,
    output req_off, req_end, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_oob
  );

  modport slave (
    input  req_valid, req_sweep, req_sel,
    input  req_off, req_end, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_oob
  );
endinterface

// File: rtl/field_reader.sv
// Banked part-select reader with a multi-cycle field-sum sweep.
// FIELD_READER_SAT_EN makes the sweep accumulator saturate.
module field_reader #(
  parameter int NWORDS = 2,
  parameter int WIDTH  = 32,
  parameter int FW     = 8,
  parameter int OFFW   = 8,
  parameter int ACCW   = 16,
  localparam int SELW  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_sel,
  input  logic [WIDTH-1:0]  wr_data,
  field_reader_if.slave     bus,
  output logic              busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic signed [OFFW+1:0] LIM = (OFFW+2)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SWEEP, RESP} state_t;

  state_t            state;
  logic [WIDTH-1:0]  bank [NWORDS];
  logic [SELW-1:0]   sel_q;
  logic [OFFW:0]     cur;
  logic [OFFW:0]     end_q;
  logic [ACCW-1:0]   acc;
  logic              oob_q;

  logic [SELW-1:0]          f_sel;
  logic signed [OFFW+1:0]   f_off;
  logic signed [OFFW+1:0]   pos;
  logic [WIDTH-1:0]         word;
  logic                     hit;
  logic [FW-1:0]            fld;
  logic                     f_oob;
  logic [ACCW:0]            sum;
  logic [ACCW-1:0]          acc_nx;
  logic [OFFW:0]            cur_nx;
  logic                     empty;

  always_comb begin
    f_sel = (state == IDLE) ? bus.req_sel : sel_q;
    f_off = (state == IDLE)
          ? {{2{bus.req_off[OFFW-1]}}, bus.req_off}
          : {cur[OFFW], cur};
    word = '0;
    hit  = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      if (f_sel == SELW'(i)) begin
        word = bank[i];
        hit  = 1'b1;
      end
    end
    // offsets are widened by two bits so off+k can never wrap
    fld   = '0;
    f_oob = 1'b0;
    pos   = '0;
    for (int k = 0; k < FW; k++) begin
      pos = f_off + (OFFW+2)'(k);
      if (hit && !pos[OFFW+1] && pos < LIM)
        fld[k] = word[pos[IW-1:0]];
      else
        f_oob = 1'b1;
    end
  end

  always_comb begin
    sum = {1'b0, acc} + (ACCW+1)'(fld);
`ifdef FIELD_READER_SAT_EN
    acc_nx = sum[ACCW] ? '1 : sum[ACCW-1:0];
`else
    acc_nx = sum[ACCW-1:0];
`endif
    cur_nx = cur + (OFFW+1)'(1);
    empty  = $signed(bus.req_end) <= $signed(bus.req_off);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NWORDS; i++) begin
      if (rst)
        bank[i] <= '0;
      else if (wr_en && wr_sel == SELW'(i))
        bank[i] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_oob   <= 1'b0;
      busy          <= 1'b0;
      sel_q         <= '0;
      cur           <= '0;
      end_q         <= '0;
      acc           <= '0;
      oob_q         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sel_q         <= bus.req_sel;
            cur           <= {bus.req_off[OFFW-1], bus.req_off};
            end_q         <= {bus.req_end[OFFW-1], bus.req_end};
            acc           <= '0;
            oob_q         <= 1'b0;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (!bus.req_sweep) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= ACCW'(fld);
              bus.rsp_oob   <= f_oob;
            end else if (empty) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_oob   <= 1'b0;
            end else begin
              state <= SWEEP;
            end
          end
        end
        SWEEP: begin
          acc   <= acc_nx;
          oob_q <= oob_q | f_oob;
          cur   <= cur_nx;
          if (cur_nx == end_q) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= acc_nx;
            bus.rsp_oob   <= oob_q | f_oob;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_field_reader.sv
// Scoreboard bench for field_reader.
module tb_field_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [0:0]  wr_sel;
  logic [31:0] wr_data;
  logic        busy;
  logic        busy8;

  always #5 clk = ~clk;

  field_reader_if #(.SELW(1), .OFFW(8), .ACCW(16)) f ();
  field_reader_if #(.SELW(1), .OFFW(8), .ACCW(8)) f8 ();

  field_reader dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .bus(f.slave), .busy(busy)
  );

  field_reader #(.ACCW(8)) dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .bus(f8.slave), .busy(busy8)
  );

  typedef struct {
    logic [15:0] data;
    logic        oob;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] fld_m(input logic [31:0] w, input int o);
    logic [7:0] d;
    logic       ob;
    d  = '0;
    ob = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (o + k >= 0 && o + k < 32) d[k] = w[o+k];
      else ob = 1'b1;
    end
    return {ob, 8'h00, d};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (f.rsp_valid && !prev_v) begin
        if (q.size() == 0) check("unexpected_rsp", 1, 0);
        else check("latency", cyc - q[0].cyc, q[0].lat);
      end
      if (f.rsp_valid && f.rsp_ready && q.size() != 0) begin
        e = q.pop_front();
        check("rsp_data", f.rsp_data, e.data);
        check("rsp_oob", f.rsp_oob, e.oob);
      end
      prev_v = f.rsp_valid;
    end
  end

  task automatic wr(input int sel, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel[0:0];
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mem[sel] = d;
  endtask

  task automatic send_exp(input bit sw, input int sel, input int off,
                          input int en, input logic [15:0] d,
                          input logic ob, input int lat);
    int n = 0;
    exp_t e;
    while (!f.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!f.req_ready) check("req_ready_timeout", 0, 1);
    e.data = d;
    e.oob  = ob;
    e.lat  = lat;
    e.cyc  = cyc;
    q.push_back(e);
    f.req_valid = 1'b1;
    f.req_sweep = sw;
    f.req_sel   = sel[0:0];
    f.req_off   = off[7:0];
    f.req_end   = en[7:0];
    @(negedge clk);
    f.req_valid = 1'b0;
  endtask

  task automatic send(input bit sw, input int sel, input int off,
                      input int en);
    logic [16:0] r;
    logic [15:0] s;
    logic        ob;
    if (!sw) begin
      r = fld_m(mem[sel], off);
      send_exp(0, sel, off, en, r[15:0], r[16], 1);
    end else begin
      s  = '0;
      ob = 1'b0;
      for (int o = off; o < en; o++) begin
        r  = fld_m(mem[sel], o);
        s  = s + r[15:0];
        ob = ob | r[16];
      end
      send_exp(1, sel, off, en, s, ob, (en > off) ? en - off + 1 : 1);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !f.req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", n < 300, 1);
  endtask

  initial begin
    int n;
    int off;
    int en;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_sel = '0;
    wr_data = '0;
    f.req_valid = 1'b0; f.req_sweep = 1'b0; f.req_sel = '0;
    f.req_off = '0; f.req_end = '0; f.rsp_ready = 1'b1;
    f8.req_valid = 1'b0; f8.req_sweep = 1'b0; f8.req_sel = '0;
    f8.req_off = '0; f8.req_end = '0; f8.rsp_ready = 1'b1;
    mem[0] = '0;
    mem[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", f.req_ready, 1);
    check("rst_rsp_valid", f.rsp_valid, 0);
    check("rst_rsp_data", f.rsp_data, 0);
    check("rst_rsp_oob", f.rsp_oob, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    send_exp(0, 0, 0, 0, 16'h0000, 0, 1); wait_done();
    send_exp(0, 1, 0, 0, 16'h0000, 0, 1); wait_done();

    wr(1, 32'hA5C3_0F81);
    send_exp(0, 1, 4, 0, 16'h00F8, 0, 1); wait_done();

    wr(0, 32'hFFFF_FFFF);
    send_exp(0, 0, -3, 0, 16'h00F8, 1, 1); wait_done();
    send_exp(0, 0, 28, 0, 16'h000F, 1, 1); wait_done();
    send_exp(0, 0, 40, 0, 16'h0000, 1, 1); wait_done();

    f8.req_valid = 1'b1; f8.req_sweep = 1'b1; f8.req_sel = '0;
    f8.req_off = 8'd0; f8.req_end = 8'd4;
    @(negedge clk);
    f8.req_valid = 1'b0;
    n = 0;
    while (!f8.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("acc8_arrived", f8.rsp_valid, 1);
`ifdef FIELD_READER_SAT_EN
    check("acc8_data", f8.rsp_data, 8'hFF);
`else
    check("acc8_data", f8.rsp_data, 8'hFC);
`endif
    check("acc8_oob", f8.rsp_oob, 0);
    @(negedge clk);

    wr(0, 32'h0000_00FF);
    send_exp(1, 0, 0, 4, 16'h01DC, 0, 5); wait_done();
    send_exp(1, 0, -10, 10, 16'h07F8, 1, 21); wait_done();
    send_exp(1, 0, 5, 5, 16'h0000, 0, 1); wait_done();
    send_exp(1, 0, 5, -2, 16'h0000, 0, 1); wait_done();

    wr_en = 1'b1; wr_sel = 1'b1; wr_data = '0;
    send_exp(0, 1, 4, 0, 16'h00F8, 0, 1);
    wr_en = 1'b0;
    mem[1] = '0;
    wait_done();
    send_exp(0, 1, 4, 0, 16'h0000, 0, 1); wait_done();

    @(posedge clk); #1 f.rsp_ready = 1'b0;
    @(negedge clk);
    send_exp(0, 0, 0, 0, 16'h00FF, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", f.rsp_valid, 1);
      check("bp_data", f.rsp_data, 16'h00FF);
      check("bp_req_ready", f.req_ready, 0);
      if (i == 0) begin
        f.req_valid = 1'b1; f.req_sweep = 1'b1;
        f.req_off = 8'd0; f.req_end = 8'd4;
      end else begin
        f.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    @(posedge clk); #1 f.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_valid", f.rsp_valid, 0);
    check("hold_data", f.rsp_data, 16'h00FF);
    check("bp_q_empty", q.size(), 0);

    f.req_valid = 1'b1; f.req_sweep = 1'b1; f.req_sel = '0;
    f.req_off = -8'sd10; f.req_end = 8'd10;
    @(negedge clk);
    f.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", f.rsp_valid, 0);
    check("abort_req_ready", f.req_ready, 1);
    check("abort_busy", busy, 0);
    mem[0] = '0;
    mem[1] = '0;
    repeat (30) @(negedge clk);
    check("abort_no_rsp", f.rsp_valid, 0);
    send(0, 0, 0, 0); wait_done();
    send(0, 1, 8, 0); wait_done();

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1)) wr($urandom_range(0, 1), $urandom);
      off = int'($urandom_range(0, 60)) - 20;
      if ($urandom_range(0, 1)) begin
        en = off + int'($urandom_range(0, 14)) - 2;
        send(1, $urandom_range(0, 1), off, en);
      end else begin
        send(0, $urandom_range(0, 1), off, 0);
      end
      wait_done();
    end

    check("final_q_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/field_reader.md
Name: field_reader

Overview:
- Read-side companion to the packed-array part-select write logic.
- Holds a small bank of packed words and serves indexed part-select reads, `bank[sel][off +: FW]`, with signed, possibly out-of-range offsets.
- Also runs a multi-cycle "sweep" that accumulates consecutive fields over an offset range.
- Serves as a synthesis/equivalence target for variable part-select reads and their out-of-range semantics.

Parameters:
- NWORDS, 2, number of words in the bank; SELW = max(1, clog2(NWORDS)) is a derived localparam.
- WIDTH, 32, bits per word.
- FW, 8, field width returned per part-select; must satisfy FW <= ACCW.
- OFFW, 8, width of the signed offset and end operands.
- ACCW, 16, width of the response data and the accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write strobe for the bank.
- wr_sel  in  SELW  word index for the write; a value >= NWORDS makes the write a no-op.
- wr_data  in  WIDTH  write data.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; equals (state == IDLE).
- req_sweep  in  1  0 = single read, 1 = sweep.
- req_sel  in  SELW  word index for the request.
- req_off  in  OFFW  signed start offset.
- req_end  in  OFFW  signed end offset, exclusive; used only for a sweep.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_data  out  ACCW  zero-extended field (single read) or accumulated sum (sweep).
- rsp_oob  out  1  at least one field bit was out of range during the operation.
- busy  out  1  high in SWEEP or RESP.

Behaviour:
- Reset values:
  - state = IDLE, so req_ready = 1.
  - rsp_valid = 0, rsp_data = 0, rsp_oob = 0, busy = 0.
  - All bank words = 0.
- Reset mid-sweep or mid-response aborts the operation; no response is produced.
- Bank writes:
  - Accepted in any state; the new value is visible from the next cycle.
  - A read step in the same cycle as a write sees the old value.
- Field extraction, for bit k in 0..FW-1:
  - Bit k = bank[sel][off+k] when 0 <= off+k < WIDTH and sel < NWORDS; otherwise the bit is 0 and the oob condition is raised.
  - off+k is evaluated signed at OFFW+2 bits, so it never wraps.
- States: IDLE, SWEEP, RESP.
- IDLE, on req_valid && req_ready, latch sel, off and end, clear acc and oob, then:
  - Single read: next cycle goes to RESP with rsp_data = zext(field(sel, off)). Latency is 1 cycle.
  - Sweep with end <= off (signed): the range is empty; next cycle goes to RESP with rsp_data = 0 and rsp_oob = 0.
  - Sweep otherwise: next cycle goes to SWEEP with cur = off.
- SWEEP:
  - Each cycle: acc += zext(field(sel, cur)) modulo 2^ACCW, oob |= field oob, cur++.
  - The step with cur == end-1 moves to RESP, presenting the final acc.
  - N = end - off steps; if accepted at cycle T, rsp_valid rises at T+N+1.
  - cur is held at OFFW+1 bits signed, so end = max positive terminates correctly.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_oob stay stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE next cycle; rsp_valid drops and rsp_data holds its last value.
- req_valid is ignored while not in IDLE, so at most one operation is in flight. Peak single-read throughput is one per 2 cycles.
- busy = (state != IDLE).

Optional Feature:
- Macro FIELD_READER_SAT_EN.
- Defined: the sweep accumulator saturates at 2^ACCW-1 instead of wrapping. Once saturated, acc stays there for the rest of the sweep.
- Undefined: acc wraps modulo 2^ACCW. There is no other behavioural difference.

Test Plan:
1. Bank write and single read:
   - Stimulus: write word1 = 32'hA5C3_0F81, then a single read with sel=1, off=4.
   - Response: at accept+1, rsp_valid=1, rsp_data=16'h00F8, rsp_oob=0.
2. Partially out-of-range reads:
   - Stimulus: word0 = 32'hFFFF_FFFF; read off=-3, then off=28.
   - Response: off=-3 gives rsp_data=16'h00F8, rsp_oob=1; off=28 gives rsp_data=16'h000F, rsp_oob=1.
   - Stimulus: read with off=40.
   - Response: rsp_data=0, rsp_oob=1.
3. Sweep:
   - Stimulus: word0 = 32'h0000_00FF; sweep with sel=0, off=0, end=4.
   - Response: rsp_valid at accept+5, rsp_data=16'h01DC (255+127+63+31), rsp_oob=0.
   - Stimulus: sweep with off=-10, end=10 on the same word.
   - Response: rsp_valid at accept+21, rsp_oob=1.
4. Empty sweep:
   - Stimulus: off=5, end=5; then off=5, end=-2.
   - Response: both give rsp_valid at accept+1, rsp_data=0, rsp_oob=0.
5. Backpressure and reset:
   - Stimulus: hold rsp_ready=0 for 3 cycles while pulsing req_valid.
   - Response: rsp_data stays stable, req_ready=0, and the extra request is dropped.
   - Stimulus: assert rst during a sweep.
   - Response: next cycle rsp_valid=0, req_ready=1, bank=0, and no response follows.
6. Accumulator overflow, with ACCW=8, word0 = all ones, sweep off=0, end=4:
   - Response without the macro: rsp_data=8'hFC.
   - Response with FIELD_READER_SAT_EN defined: rsp_data=8'hFF.
